// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, pointer-width helper and clog2.
// Used by both the single-clock and dual-clock FIFO controllers.
package fifo_pkg;
  localparam int FIFO_WIDTH_DEF   = 16;
  localparam int FIFO_DEPTH_DEF   = 512;
  localparam int ADDRESS_SIZE_DEF = 9;
  localparam int PTR_W            = ADDRESS_SIZE_DEF + 1;

  // One extra pointer bit tells full from empty when the address bits match
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer-facing bundle of the single-clock FIFO.
// The master side drives data, requests and thresholds; the slave is the FIFO.
interface sync_fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH   = FIFO_WIDTH_DEF,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
);
  logic [FIFO_WIDTH-1:0] din;
  logic [FIFO_WIDTH-1:0] dout;
  logic                  wen;
  logic                  ren;
  logic                  err_clr;
  logic [ADDRESS_SIZE:0] af_thresh;
  logic [ADDRESS_SIZE:0] ae_thresh;
  logic [ADDRESS_SIZE:0] count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wen, ren, err_clr, af_thresh, ae_thresh,
    input  dout, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  din, wen, ren, err_clr, af_thresh, ae_thresh,
    output dout, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, read port registered (ASYNC_RD=0)
// or combinational (ASYNC_RD=1). Only the read register is reset, never the array.
module fifo_ram #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 9,
  parameter bit ASYNC_RD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (ASYNC_RD) begin : g_async
      logic unused_rd;
      assign unused_rd = re ^ rst_n;
      assign rdata = mem[raddr];
    end else begin : g_sync
      logic [WIDTH-1:0] rd_q, rd_d;

      always_comb begin
        rd_d = rd_q;
        if (re) rd_d = mem[raddr];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
      end

      assign rdata = rd_q;
    end
  endgenerate
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through (combinational dout).
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH   = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int ADDRESS_SIZE = clog2(FIFO_DEPTH)
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int PW = ptr_w(ADDRESS_SIZE);
`ifdef FIFO_FWFT_EN
  localparam bit ASYNC_RD = 1'b1;
`else
  localparam bit ASYNC_RD = 1'b0;
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          full, empty, wr_acc, rd_acc;

  always_comb begin
    cnt    = wr_ptr_q - rd_ptr_q;
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
             (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    wr_acc = bus.wen && !full;
    rd_acc = bus.ren && !empty;
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    // A new error in the clearing cycle wins over the clear
    ovf_d = (ovf_q && !bus.err_clr) || (bus.wen && full);
    unf_d = (unf_q && !bus.err_clr) || (bus.ren && empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .WIDTH   (FIFO_WIDTH),
    .ADDR_W  (ADDRESS_SIZE),
    .ASYNC_RD(ASYNC_RD)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst),
    .we   (wr_acc),
    .waddr(wr_ptr_q[ADDRESS_SIZE-1:0]),
    .wdata(bus.din),
    .re   (rd_acc),
    .raddr(rd_ptr_q[ADDRESS_SIZE-1:0]),
    .rdata(bus.dout)
  );

  assign bus.count        = cnt;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= bus.af_thresh);
  assign bus.almost_empty = (cnt <= bus.ae_thresh);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: fill/drain, wrap, collisions, thresholds, async reset.
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.FIFO_WIDTH(16), .ADDRESS_SIZE(9)) bus ();
  sync_fifo_ctrl #(.FIFO_WIDTH(16), .FIFO_DEPTH(512), .ADDRESS_SIZE(9)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int wv = 0;  // next value to write
  int rv = 0;  // next value expected out

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [15:0] d);
    bus.wen = w; bus.ren = r; bus.din = d;
    tick();
    bus.wen = 1'b0; bus.ren = 1'b0;
  endtask

  initial begin
    bus.din = '0; bus.wen = 1'b0; bus.ren = 1'b0; bus.err_clr = 1'b0;
    bus.af_thresh = 10'd500; bus.ae_thresh = 10'd4;
    #12;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ae", 32'(bus.almost_empty), 1);
    chk("rst_af", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    rst = 1'b1;
`ifdef FIFO_FWFT_EN
    drive(1'b1, 1'b0, 16'hA5A5);
    chk("fwft_empty", 32'(bus.empty), 0);
    chk("fwft_first", 32'(bus.dout), 32'hA5A5);
    drive(1'b1, 1'b0, 16'h5A5A);
    chk("fwft_hold", 32'(bus.dout), 32'hA5A5);
    chk("fwft_cnt2", 32'(bus.count), 2);
    drive(1'b0, 1'b1, 16'h0);
    chk("fwft_next", 32'(bus.dout), 32'h5A5A);
    chk("fwft_cnt1", 32'(bus.count), 1);
    drive(1'b0, 1'b1, 16'h0);
    chk("fwft_drained", 32'(bus.empty), 1);
    drive(1'b1, 1'b1, 16'h0077);
    chk("fwft_wr_cnt", 32'(bus.count), 1);
    chk("fwft_unf", 32'(bus.underflow), 1);
    chk("fwft_wr_data", 32'(bus.dout), 32'h0077);
`else
    chk("rst_dout", 32'(bus.dout), 0);
    // Fill to full with 0x0000..0x01FF
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 1'b0, 16'(wv)); wv++;
      if (i == 498) chk("af_below", 32'(bus.almost_full), 0);
      if (i == 499) chk("af_at", 32'(bus.almost_full), 1);
    end
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 512);
    chk("fill_af", 32'(bus.almost_full), 1);
    drive(1'b1, 1'b0, 16'hDEAD);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 512);
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, 1'b1, 16'h0);
      chk("drain_data", 32'(bus.dout), 32'(16'(rv))); rv++;
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_count", 32'(bus.count), 0);
    drive(1'b0, 1'b1, 16'h0);
    chk("unf_set", 32'(bus.underflow), 1);
    chk("unf_dout_hold", 32'(bus.dout), 32'h01FF);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 0);
    chk("clr_unf", 32'(bus.underflow), 0);
    // Three rounds of 306 words push wr_ptr past 1023
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) begin drive(1'b1, 1'b0, 16'(wv)); wv++; end
      for (int i = 0; i < 50; i++) begin
        drive(1'b1, 1'b1, 16'(wv)); wv++;
        chk("wrap_cnt", 32'(bus.count), 256);
        chk("wrap_both", 32'(bus.dout), 32'(16'(rv))); rv++;
      end
      for (int i = 0; i < 256; i++) begin
        drive(1'b0, 1'b1, 16'h0);
        chk("wrap_data", 32'(bus.dout), 32'(16'(rv))); rv++;
      end
    end
    chk("wrap_empty", 32'(bus.empty), 1);
    // Full with simultaneous write+read
    for (int i = 0; i < 512; i++) begin drive(1'b1, 1'b0, 16'(wv)); wv++; end
    drive(1'b1, 1'b1, 16'hBEEF);
    chk("full_rw_data", 32'(bus.dout), 32'(16'(rv))); rv++;
    chk("full_rw_ovf", 32'(bus.overflow), 1);
    chk("full_rw_cnt", 32'(bus.count), 511);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    chk("clr_ovf2", 32'(bus.overflow), 0);
    drive(1'b1, 1'b0, 16'(wv)); wv++;
    chk("refull", 32'(bus.full), 1);
    bus.err_clr = 1'b1;
    drive(1'b1, 1'b0, 16'hBEEF);
    bus.err_clr = 1'b0;
    chk("set_beats_clr", 32'(bus.overflow), 1);
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, 1'b1, 16'h0);
      chk("full_drain", 32'(bus.dout), 32'(16'(rv))); rv++;
    end
    // Thresholds from a fresh reset
    rst = 1'b0; #1; rst = 1'b1;
    rv = wv;
    bus.ae_thresh = 10'd4; bus.af_thresh = 10'd8;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0, 16'(wv)); wv++;
      chk("thr_ae", 32'(bus.almost_empty), 32'(i <= 4));
      chk("thr_af", 32'(bus.almost_full), 32'(i >= 8));
    end
    drive(1'b0, 1'b1, 16'h0);
    chk("thr_rd", 32'(bus.dout), 32'(16'(rv))); rv++;
    // Async reset mid-burst, checked before the next edge
    bus.wen = 1'b1; bus.din = 16'(wv);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_dout", 32'(bus.dout), 0);
    bus.wen = 1'b0;
    rst = 1'b1;
    // Empty with simultaneous write+read
    drive(1'b1, 1'b1, 16'h1234);
    chk("empty_rw_cnt", 32'(bus.count), 1);
    chk("empty_rw_unf", 32'(bus.underflow), 1);
    chk("empty_rw_dout", 32'(bus.dout), 0);
    drive(1'b0, 1'b1, 16'h0);
    chk("empty_rw_data", 32'(bus.dout), 32'h1234);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
